// File: rtl/i2c_rx_if.sv
// I2C bus bundle: resolved SCL/SDA levels plus the target's open-drain pull-down.
// sda_pull=1 pulls SDA to 0; sda_pull=0 releases SDA ('z', pulled up).
interface i2c_if;
    logic scl;
    logic sda;
    logic sda_pull;

    modport target (
        input  scl,
        input  sda,
        output sda_pull
    );

    modport bus (
        output scl,
        output sda,
        input  sda_pull
    );
endinterface

// File: rtl/i2c_rx.sv
// I2C write-direction target: detects START/STOP, matches ADDR+W,
// shifts in data bytes and answers ACK/NAK by pulling SDA low.
module i2c_rx #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    i2c_if.target       i2c,
    input  logic        en,
    input  logic        nak,
    output logic [7:0]  data,
    output logic        data_en,
    output logic        addr_match,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t r_state, w_state;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic r_scl_d, r_sda_d;
    logic w_scl, w_sda;
    logic w_rise, w_fall, w_start, w_stop;

    logic [7:0] r_shift, w_shift;
    logic [2:0] r_cnt, w_cnt;
    logic       r_got, w_got;
    logic       r_pull, w_pull;
    logic [7:0] r_data, w_data;
    logic       r_data_en, w_data_en;
    logic       r_match, w_match;
    logic       r_busy, w_busy;

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;
    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_got      <= 1'b0;
            r_pull     <= 1'b0;
            r_data     <= '0;
            r_data_en  <= 1'b0;
            r_match    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c.scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c.sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_cnt      <= w_cnt;
            r_got      <= w_got;
            r_pull     <= w_pull;
            r_data     <= w_data;
            r_data_en  <= w_data_en;
            r_match    <= w_match;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_cnt     = r_cnt;
        w_got     = r_got;
        w_pull    = r_pull;
        w_data    = r_data;
        w_data_en = 1'b0;
        w_match   = r_match;
        w_busy    = r_busy;

        if (w_rise && (r_state == S_ADDR || r_state == S_DATA)) begin
            w_shift = {r_shift[6:0], w_sda};
            w_got   = 1'b1;
        end

        if (w_start) begin
            w_pull  = 1'b0;
            w_cnt   = '0;
            w_got   = 1'b0;
            w_busy  = 1'b1;
            w_match = 1'b0;
            w_state = en ? S_ADDR : S_IDLE;
        end else if (w_stop) begin
            w_pull  = 1'b0;
            w_cnt   = '0;
            w_got   = 1'b0;
            w_busy  = 1'b0;
            w_match = 1'b0;
            w_state = S_IDLE;
        end else if (w_fall) begin
            unique case (r_state)
                S_ADDR: begin
                    // The falling edge right after START carries no bit.
                    if (r_got) begin
                        w_got = 1'b0;
                        w_cnt = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_cnt = '0;
                            if (en && r_shift[7:1] == ADDR && !r_shift[0]) begin
                                w_pull  = 1'b1;
                                w_match = 1'b1;
                                w_state = S_ADDR_ACK;
                            end else begin
                                w_state = S_IGNORE;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (!en) begin
                        w_pull  = 1'b0;
                        w_state = S_IGNORE;
                    end else if (r_got) begin
                        w_got = 1'b0;
                        w_cnt = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_cnt     = '0;
                            w_data    = r_shift;
                            w_data_en = 1'b1;
                            w_pull    = ~nak;
                            w_state   = S_DATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    w_pull  = 1'b0;
                    w_cnt   = '0;
                    w_got   = 1'b0;
                    w_state = en ? S_DATA : S_IGNORE;
                end
                S_DATA_ACK: begin
                    w_pull  = 1'b0;
                    w_cnt   = '0;
                    w_got   = 1'b0;
                    w_state = (en && r_pull) ? S_DATA : S_IGNORE;
                end
                default: ;
            endcase
        end
    end

    // Gating with rstn lets a reset release SDA without waiting for an edge.
    assign i2c.sda_pull = r_pull & rstn;
    assign data         = r_data;
    assign data_en      = r_data_en;
    assign addr_match   = r_match;
    assign busy         = r_busy;

endmodule
